// File: rtl/mem_store_unit.sv
// Store side of the MEM stage: aligns sb/sh/sw data onto byte lanes, builds the
// byte-enable mask and holds a single write request to the data cache until it answers.
module mem_store_unit #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   store_req,
    input  logic [2:0]             funct3,
    input  logic [31:0]            addr,
    input  logic [31:0]            rs2_data,
    input  logic                   mem_resp,
    output logic                   mem_write,
    output logic [31:0]            mem_address,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_byte_enable,
    output logic                   stall,
    output logic                   store_done,
    output logic                   store_fault,
    output logic [COUNT_WIDTH-1:0] store_count
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic        legal;
    logic        accept;
    logic [31:0] wdata_al;
    logic [3:0]  mask_al;

    // Lane alignment of the incoming store; only meaningful when legal is set.
    always_comb begin
        legal    = 1'b0;
        wdata_al = rs2_data;
        mask_al  = 4'b0000;
        unique case (funct3)
            3'b000: begin
                legal    = 1'b1;
                wdata_al = {4{rs2_data[7:0]}};
                mask_al  = 4'b0001 << addr[1:0];
            end
            3'b001: begin
                legal    = ~addr[0];
                wdata_al = {2{rs2_data[15:0]}};
                mask_al  = addr[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                legal    = (addr[1:0] == 2'b00);
                wdata_al = rs2_data;
                mask_al  = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        store_done  = 1'b0;
        store_fault = 1'b0;
        accept      = 1'b0;
        unique case (state)
            IDLE: begin
                if (store_req) begin
                    if (legal) begin
                        accept    = 1'b1;
                        stall     = 1'b1;
                        state_nxt = BUSY;
                    end else begin
                        store_fault = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    store_done = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset is asynchronous, so the combinational strobes must also vanish at once.
        if (rst) begin
            stall       = 1'b0;
            store_done  = 1'b0;
            store_fault = 1'b0;
            accept      = 1'b0;
        end
    end

    assign mem_write = (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            store_count     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mem_address     <= {addr[31:2], 2'b00};
                mem_wdata       <= wdata_al;
                mem_byte_enable <= mask_al;
            end
            if (store_done)
                store_count <= store_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: directed scenarios plus a randomized run against a
// transaction-level model of the store unit (small counter width to exercise wrap).
module tb_mem_store_unit;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          store_req = 1'b0;
    logic [2:0]    funct3 = 3'b000;
    logic [31:0]   addr = '0;
    logic [31:0]   rs2_data = '0;
    logic          mem_resp = 1'b0;
    logic          mem_write;
    logic [31:0]   mem_address;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_byte_enable;
    logic          stall;
    logic          store_done;
    logic          store_fault;
    logic [CW-1:0] store_count;

    mem_store_unit #(.COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .store_req(store_req), .funct3(funct3), .addr(addr),
        .rs2_data(rs2_data), .mem_resp(mem_resp), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .stall(stall), .store_done(store_done), .store_fault(store_fault),
        .store_count(store_count)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: one outstanding store, described as a transaction.
    bit          m_busy;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;
    int          m_count;

    logic obs_stall, obs_done, obs_fault, obs_write;
    logic exp_stall, exp_done, exp_fault;

    function automatic bit is_legal(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (f3 > 3'd2) return 1'b0;
        sz = 1 << f3;
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        b = r[7:0];
        h = r[15:0];
        if (f3 == 3'd0) return 32'(b) * 32'h0101_0101;
        if (f3 == 3'd1) return 32'(h) * 32'h0001_0001;
        return r;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int m;
        sz = 1 << f3;
        m  = ((1 << sz) - 1) << (a % 4);
        return 4'(m);
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_addr = '0; m_wdata = '0; m_mask = '0; m_count = 0;
    endtask

    // Drive one cycle: inputs at negedge, capture comb outputs, advance model at posedge.
    task automatic cycle(input logic req, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] r, input logic rp);
        bit lg;
        @(negedge clk);
        store_req = req; funct3 = f3; addr = a; rs2_data = r; mem_resp = rp;
        #1;
        obs_stall = stall; obs_done = store_done; obs_fault = store_fault; obs_write = mem_write;
        lg = is_legal(f3, a);
        if (m_busy) begin
            exp_stall = !rp; exp_done = rp; exp_fault = 1'b0;
        end else begin
            exp_stall = req && lg; exp_done = 1'b0; exp_fault = req && !lg;
        end
        @(posedge clk);
        if (m_busy) begin
            if (rp) begin
                m_busy  = 1'b0;
                m_count = (m_count + 1) % (1 << CW);
            end
        end else if (req && lg) begin
            m_busy  = 1'b1;
            m_addr  = a & ~32'd3;
            m_wdata = lane_data(f3, r);
            m_mask  = lane_mask(f3, a);
        end
        #1;
    endtask

    task automatic test_reset();
        store_req = 1'b1; funct3 = 3'b000; addr = 32'h10; rs2_data = 32'hFF;
        #12;
        nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b exp 0", stall); end
        nchk++; if (store_fault !== 1'b0 || store_done !== 1'b0) begin nerr++; $display("FAIL reset_strobes got fault=%b done=%b exp 0", store_fault, store_done); end
        nchk++; if ({mem_write, mem_address, mem_wdata, mem_byte_enable, store_count} !== '0) begin
            nerr++; $display("FAIL reset_regs got w=%b a=%h d=%h m=%b c=%0d exp 0", mem_write, mem_address, mem_wdata, mem_byte_enable, store_count);
        end
        @(negedge clk);
        rst = 1'b0; store_req = 1'b0;
        model_reset();
    endtask

    task automatic test_sb();
        int stall_cycles = 0;
        cycle(1, 3'b000, 32'h1003, 32'h0000_00A5, 0);
        stall_cycles += obs_stall;
        nchk++; if (mem_write !== 1'b1) begin nerr++; $display("FAIL sb_write got %b exp 1", mem_write); end
        nchk++; if (mem_address !== 32'h1000) begin nerr++; $display("FAIL sb_addr got %h exp 00001000", mem_address); end
        nchk++; if (mem_wdata !== 32'hA5A5_A5A5) begin nerr++; $display("FAIL sb_wdata got %h exp a5a5a5a5", mem_wdata); end
        nchk++; if (mem_byte_enable !== 4'b1000) begin nerr++; $display("FAIL sb_mask got %b exp 1000", mem_byte_enable); end
        for (int i = 0; i < 2; i++) begin
            cycle(1, 3'b000, 32'h1003, 32'h0000_00A5, 0);
            stall_cycles += obs_stall;
        end
        cycle(1, 3'b000, 32'h1003, 32'h0000_00A5, 1);
        stall_cycles += obs_stall;
        nchk++; if (obs_done !== 1'b1) begin nerr++; $display("FAIL sb_done got %b exp 1", obs_done); end
        nchk++; if (stall_cycles != 3) begin nerr++; $display("FAIL sb_stall_cycles got %0d exp 3", stall_cycles); end
        nchk++; if (mem_write !== 1'b0 || store_count !== 4'd1) begin nerr++; $display("FAIL sb_after got w=%b c=%0d exp w=0 c=1", mem_write, store_count); end
    endtask

    task automatic test_sh();
        int write_cycles;
        cycle(1, 3'b001, 32'h2002, 32'h1234_BEEF, 0);
        write_cycles = mem_write;
        nchk++; if (mem_wdata !== 32'hBEEF_BEEF || mem_byte_enable !== 4'b1100) begin
            nerr++; $display("FAIL sh_lane got d=%h m=%b exp d=beefbeef m=1100", mem_wdata, mem_byte_enable);
        end
        cycle(1, 3'b001, 32'h2002, 32'h1234_BEEF, 1);
        write_cycles += mem_write;
        cycle(0, 3'b000, 32'h0, 32'h0, 0);
        write_cycles += mem_write;
        nchk++; if (write_cycles != 1 || obs_write !== 1'b0) begin nerr++; $display("FAIL sh_write_len got %0d exp 1", write_cycles); end
        nchk++; if (store_count !== 4'd2) begin nerr++; $display("FAIL sh_count got %0d exp 2", store_count); end
    endtask

    task automatic test_fault();
        logic [2:0] f3s [2];
        logic [31:0] as [2];
        f3s[0] = 3'b010; as[0] = 32'h3001;
        f3s[1] = 3'b011; as[1] = 32'h3000;
        for (int i = 0; i < 2; i++) begin
            cycle(1, f3s[i], as[i], 32'hDEAD_BEEF, 0);
            nchk++; if (obs_fault !== 1'b1 || obs_stall !== 1'b0) begin
                nerr++; $display("FAIL fault_%0d got fault=%b stall=%b exp fault=1 stall=0", i, obs_fault, obs_stall);
            end
            nchk++; if (mem_write !== 1'b0 || store_count !== 4'd2 || mem_address !== 32'h2000) begin
                nerr++; $display("FAIL fault_noaccess_%0d got w=%b c=%0d a=%h exp w=0 c=2 a=00002000", i, mem_write, store_count, mem_address);
            end
        end
        cycle(0, 3'b000, 32'h0, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] wr;
        cycle(1, 3'b010, 32'h5000, 32'h1111_1111, 0);  wr[0] = mem_write;
        cycle(1, 3'b010, 32'h5000, 32'h1111_1111, 1);  wr[1] = mem_write;
        cycle(1, 3'b010, 32'h5004, 32'h2222_2222, 0);  wr[2] = mem_write;
        nchk++; if (mem_wdata !== 32'h2222_2222 || mem_address !== 32'h5004) begin
            nerr++; $display("FAIL b2b_second got a=%h d=%h exp a=00005004 d=22222222", mem_address, mem_wdata);
        end
        cycle(1, 3'b010, 32'h5004, 32'h2222_2222, 1);  wr[3] = mem_write;
        nchk++; if (wr !== 4'b0101) begin nerr++; $display("FAIL b2b_windows got %b exp 0101", wr); end
        nchk++; if (store_count !== 4'd4) begin nerr++; $display("FAIL b2b_count got %0d exp 4", store_count); end
        cycle(0, 3'b000, 32'h0, 32'h0, 0);
    endtask

    task automatic test_hold_inputs();
        cycle(1, 3'b000, 32'h6001, 32'h0000_0077, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 3'b010, 32'h7000 + 32'(i * 4), $urandom, 0);
            nchk++; if (mem_address !== 32'h6000 || mem_wdata !== 32'h7777_7777 || mem_byte_enable !== 4'b0010) begin
                nerr++; $display("FAIL hold_%0d got a=%h d=%h m=%b exp a=00006000 d=77777777 m=0010", i, mem_address, mem_wdata, mem_byte_enable);
            end
        end
        cycle(0, 3'b000, 32'h0, 32'h0, 1);
        cycle(0, 3'b000, 32'h0, 32'h0, 0);
    endtask

    task automatic test_reset_mid();
        cycle(1, 3'b010, 32'h8000, 32'h5555_AAAA, 0);
        cycle(1, 3'b010, 32'h8000, 32'h5555_AAAA, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        nchk++; if (mem_write !== 1'b0 || stall !== 1'b0 || store_count !== '0) begin
            nerr++; $display("FAIL rstmid got w=%b s=%b c=%0d exp 0", mem_write, stall, store_count);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0; store_req = 1'b0;
        cycle(0, 3'b000, 32'h0, 32'h0, 1);
        nchk++; if (obs_done !== 1'b0 || store_count !== '0 || mem_write !== 1'b0) begin
            nerr++; $display("FAIL late_resp got done=%b c=%0d w=%b exp 0", obs_done, store_count, mem_write);
        end
        cycle(1, 3'b010, 32'h9000, 32'hCAFE_F00D, 0);
        cycle(1, 3'b010, 32'h9000, 32'hCAFE_F00D, 1);
        nchk++; if (obs_done !== 1'b1 || store_count !== 4'd1) begin
            nerr++; $display("FAIL post_rst_sw got done=%b c=%0d exp done=1 c=1", obs_done, store_count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) begin
            cycle(1, 3'b000, 32'(i), 32'(i), 0);
            cycle(1, 3'b000, 32'(i), 32'(i), 1);
            nchk++; if (store_count !== 4'(m_count)) begin
                nerr++; $display("FAIL wrap_%0d got %0d exp %0d", i, store_count, m_count);
            end
        end
    endtask

    task automatic test_random();
        logic        req, rp;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 3) != 0);
            f3  = 3'($urandom_range(0, 4));
            a   = $urandom;
            rp  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            cycle(req, f3, a, $urandom, rp);
            nchk++; if ({obs_stall, obs_done, obs_fault} !== {exp_stall, exp_done, exp_fault}) begin
                nerr++; $display("FAIL rnd_comb_%0d got s/d/f=%b%b%b exp %b%b%b", i, obs_stall, obs_done, obs_fault, exp_stall, exp_done, exp_fault);
            end
            nchk++; if (mem_write !== m_busy || store_count !== 4'(m_count)) begin
                nerr++; $display("FAIL rnd_state_%0d got w=%b c=%0d exp w=%b c=%0d", i, mem_write, store_count, m_busy, m_count);
            end
            if (m_busy) begin
                nchk++; if (mem_address !== m_addr || mem_wdata !== m_wdata || mem_byte_enable !== m_mask) begin
                    nerr++; $display("FAIL rnd_req_%0d got a=%h d=%h m=%b exp a=%h d=%h m=%b", i, mem_address, mem_wdata, mem_byte_enable, m_addr, m_wdata, m_mask);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sb();
        test_sh();
        test_fault();
        test_back_to_back();
        test_hold_inputs();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
